// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared constants, R1 layout and FSM states for the SD SPI responder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package sd_spi_pkg;

  // Command indices the responder understands
  localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
  localparam logic [5:0] ACMD_SEND_OP     = 6'd41;
  localparam logic [5:0] CMD_APP_CMD      = 6'd55;

  // R1 response bit positions
  localparam int R1_IDLE_BIT    = 0;
  localparam int R1_ERASE_BIT   = 1;
  localparam int R1_ILLEGAL_BIT = 2;
  localparam int R1_CRC_ERR_BIT = 3;

  // CRC7 generator x^7 + x^3 + 1, high term implicit
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Accepted CMD8 supply-voltage code (2.7-3.6 V)
  localparam logic [3:0] R7_VHS_OK = 4'h1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_DECODE,
    S_NCR,
    S_TX
  } state_t;

  function automatic logic [7:0] r1_byte(input logic idle, input logic illegal,
                                         input logic crc_err);
    logic [7:0] r;
    r                 = 8'h00;
    r[R1_IDLE_BIT]    = idle;
    r[R1_ILLEGAL_BIT] = illegal;
    r[R1_CRC_ERR_BIT] = crc_err;
    return r;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 over a bit stream, one bit per enabled cycle, MSB first.
// Latency: result reflects a bit one clk_ref cycle after its enable.
// Backpressure: none; clr has priority over en.
module sd_crc7
  import sd_spi_pkg::*;
(
  input  logic       clk_ref,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic       fb;
  logic [6:0] crc_next;

  // Next CRC value: shift left, fold in the polynomial when the feedback is set
  always_comb begin
    fb       = crc[6] ^ bit_in;
    crc_next = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end

  // CRC register
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      crc <= 7'h00;
    end else if (clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SD-card SPI-mode responder for CMD0/CMD8/CMD55/ACMD41 (R1/R7); CRC7 check under SDR_CRC_CHECK_EN.
// Latency: NCR_BYTES of 0xFF after the end bit, then the response; sd_miso follows sd_clk falls by SYNC_STAGES+1 clk_ref.
// Backpressure: none; the host paces everything with sd_clk, and sd_cs high aborts to idle at once.
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int NCR_BYTES       = 1,
  parameter int ACMD41_BUSY_CNT = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk_ref,
  input  logic       rst,
  input  logic       sd_clk,
  input  logic       sd_cs,
  input  logic       sd_mosi,
  output logic       sd_miso,
  output logic       cmd_valid,
  output logic [5:0] cmd_index,
  output logic       card_ready
);

  // A zero-width counter is not legal, so a busy count of 0 still gets one bit
  localparam int BUSY_W_RAW = $clog2(ACMD41_BUSY_CNT + 1);
  localparam int BUSY_W     = (BUSY_W_RAW < 1) ? 1 : BUSY_W_RAW;
  localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(ACMD41_BUSY_CNT);

  localparam int NCR_BITS = NCR_BYTES * 8;
  localparam int NCR_W    = $clog2(NCR_BITS + 1);
  localparam logic [NCR_W-1:0] NCR_LAST = NCR_W'(NCR_BITS - 1);

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, mosi_sync;
  logic clk_s, cs_s, mosi_s, clk_prev;
  logic sck_rise, sck_fall;

  // FSM and datapath
  state_t      state, next_state;
  logic [47:0] rx_sr;
  logic [5:0]  bit_cnt;
  logic [NCR_W-1:0] ncr_cnt;
  logic [39:0] tx_sr;
  logic [5:0]  tx_cnt;
  logic        tx_long;

  // Card state
  logic              idle, app_flag, cmd0_seen;
  logic [BUSY_W-1:0] busy_cnt;
  logic [5:0]        idx_q;

  // Decode results
  logic [5:0]        idx;
  logic              framed, crc_ok, accept;
  logic [39:0]       resp;
  logic              resp_long;
  logic              nxt_idle, nxt_app, nxt_seen;
  logic [BUSY_W-1:0] nxt_busy;
  logic [3:0]        vhs_echo;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = clk_s & ~clk_prev;
  assign sck_fall = ~clk_s & clk_prev;

  assign idx    = rx_sr[45:40];
  assign framed = ~rx_sr[47] & rx_sr[46] & rx_sr[0];
  assign vhs_echo = (rx_sr[19:16] == R7_VHS_OK) ? R7_VHS_OK : 4'h0;

  // Argument bits the responder never looks at
  logic unused_arg;
  assign unused_arg = ^rx_sr[39:20];

`ifdef SDR_CRC_CHECK_EN
  logic [6:0] crc_val;
  logic       crc_clr, crc_en;

  // The start bit is 0 and the CRC is cleared in idle, so skipping it does not change the result
  assign crc_clr = (state == S_IDLE);
  assign crc_en  = (state == S_RX) && sck_rise && (bit_cnt < 6'd40);

  sd_crc7 u_crc7 (
    .clk_ref (clk_ref),
    .rst     (rst),
    .clr     (crc_clr),
    .en      (crc_en),
    .bit_in  (mosi_s),
    .crc     (crc_val)
  );

  // Only CMD0 and CMD8 are CRC-checked; everything else passes
  assign crc_ok = ((idx != CMD_GO_IDLE) && (idx != CMD_SEND_IF_COND)) ||
                  (crc_val == rx_sr[7:1]);
`else
  logic unused_crc;
  assign unused_crc = ^rx_sr[7:1];
  assign crc_ok = 1'b1;
`endif

  // Bring sd_clk, sd_cs and sd_mosi into the clk_ref domain
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      clk_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
      clk_prev  <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        clk_sync[i]  <= clk_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
      end
      clk_sync[0]  <= sd_clk;
      cs_sync[0]   <= sd_cs;
      mosi_sync[0] <= sd_mosi;
      clk_prev     <= clk_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, command decode, response build and card-state update
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    resp       = '1;
    resp_long  = 1'b0;
    nxt_idle   = idle;
    nxt_app    = app_flag;
    nxt_busy   = busy_cnt;
    nxt_seen   = cmd0_seen;
    if (cs_s) begin
      next_state = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (sck_rise && !mosi_s) next_state = S_RX;
        S_RX:   if (sck_rise && (bit_cnt == 6'd47)) next_state = S_DECODE;
        S_DECODE: begin
          next_state = S_IDLE;
          // Until the first CMD0 the card is deaf to everything else
          if (framed && (cmd0_seen || (idx == CMD_GO_IDLE))) begin
            accept     = 1'b1;
            next_state = S_NCR;
            if (!crc_ok) begin
              resp[39:32] = r1_byte(idle, 1'b0, 1'b1);
            end else begin
              nxt_app = 1'b0;
              unique case (idx)
                CMD_GO_IDLE: begin
                  resp[39:32] = r1_byte(1'b1, 1'b0, 1'b0);
                  nxt_idle    = 1'b1;
                  nxt_busy    = '0;
                  nxt_seen    = 1'b1;
                end
                CMD_SEND_IF_COND: begin
                  resp      = {8'h01, 8'h00, 8'h00, 4'h0, vhs_echo, rx_sr[15:8]};
                  resp_long = 1'b1;
                end
                CMD_APP_CMD: begin
                  resp[39:32] = r1_byte(idle, 1'b0, 1'b0);
                  nxt_app     = 1'b1;
                end
                ACMD_SEND_OP: begin
                  if (!app_flag) begin
                    resp[39:32] = r1_byte(idle, 1'b1, 1'b0);
                  end else if (busy_cnt < BUSY_MAX) begin
                    resp[39:32] = 8'h01;
                    nxt_busy    = busy_cnt + 1'b1;
                  end else begin
                    resp[39:32] = 8'h00;
                    nxt_idle    = 1'b0;
                  end
                end
                default: resp[39:32] = r1_byte(idle, 1'b1, 1'b0);
              endcase
            end
          end
        end
        S_NCR: if (sck_fall && (ncr_cnt == NCR_LAST)) next_state = S_TX;
        S_TX:  if (sck_fall && (tx_cnt == (tx_long ? 6'd39 : 6'd7))) next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Receive shifter, NCR/TX counters, transmit shifter and the sd_miso register
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      rx_sr   <= '1;
      bit_cnt <= '0;
      ncr_cnt <= '0;
      tx_sr   <= '1;
      tx_cnt  <= '0;
      tx_long <= 1'b0;
      sd_miso <= 1'b1;
    end else begin
      if (sck_rise && ((state == S_IDLE) || (state == S_RX))) begin
        rx_sr <= {rx_sr[46:0], mosi_s};
      end
      if (state == S_IDLE) begin
        bit_cnt <= 6'd1;
      end else if ((state == S_RX) && sck_rise) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == S_DECODE) begin
        ncr_cnt <= '0;
        tx_sr   <= resp;
        tx_long <= resp_long;
        tx_cnt  <= '0;
      end else if ((state == S_NCR) && sck_fall) begin
        ncr_cnt <= ncr_cnt + 1'b1;
      end else if ((state == S_TX) && sck_fall) begin
        tx_sr  <= {tx_sr[38:0], 1'b1};
        tx_cnt <= tx_cnt + 1'b1;
      end
      if (cs_s) begin
        sd_miso <= 1'b1;
      end else if (sck_fall) begin
        sd_miso <= (state == S_TX) ? tx_sr[39] : 1'b1;
      end
    end
  end

  // Card state: idle, app flag, ACMD41 busy count, CMD0 seen, last index
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      idle      <= 1'b1;
      app_flag  <= 1'b0;
      busy_cnt  <= '0;
      cmd0_seen <= 1'b0;
      idx_q     <= '0;
    end else if (accept) begin
      idle      <= nxt_idle;
      app_flag  <= nxt_app;
      busy_cnt  <= nxt_busy;
      cmd0_seen <= nxt_seen;
      idx_q     <= idx;
    end
  end

  assign cmd_valid  = accept;
  assign cmd_index  = accept ? idx : idx_q;
  assign card_ready = ~idle;

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: directed SPI transactions against sd_spi_responder with hand-computed responses.
// Latency: sd_clk runs at 1/16 of clk_ref; responses are read one NCR byte after each command.
// Backpressure: n/a; the bench is the host.
module tb_sd_spi_responder;

  logic       clk_ref = 1'b0;
  logic       rst     = 1'b0;
  logic       sd_clk  = 1'b0;
  logic       sd_cs   = 1'b1;
  logic       sd_mosi = 1'b1;
  logic       sd_miso;
  logic       cmd_valid;
  logic [5:0] cmd_index;
  logic       card_ready;

  int         n_cmp = 0;
  int         n_err = 0;
  int         vcount = 0;
  logic [5:0] last_idx = 6'd0;

  localparam logic [47:0] C_CMD0      = 48'h40_00_00_00_00_95;
  localparam logic [47:0] C_CMD0_BAD  = 48'h40_00_00_00_00_97;
  localparam logic [47:0] C_CMD8      = 48'h48_00_00_01_AA_87;
  localparam logic [47:0] C_CMD8_V0   = 48'h48_00_00_02_AA_87;
  localparam logic [47:0] C_CMD17     = 48'h51_00_00_00_00_FF;
  localparam logic [47:0] C_CMD55     = 48'h77_00_00_00_00_FF;
  localparam logic [47:0] C_ACMD41    = 48'h69_40_00_00_00_FF;
  localparam logic [47:0] C_BAD_TX    = 48'h00_00_00_00_00_01;
  localparam logic [47:0] C_BAD_END   = 48'h40_00_00_00_00_94;

  always #5 clk_ref = ~clk_ref;

  sd_spi_responder #(
    .NCR_BYTES       (1),
    .ACMD41_BUSY_CNT (2),
    .SYNC_STAGES     (2)
  ) dut (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .sd_clk     (sd_clk),
    .sd_cs      (sd_cs),
    .sd_mosi    (sd_mosi),
    .sd_miso    (sd_miso),
    .cmd_valid  (cmd_valid),
    .cmd_index  (cmd_index),
    .card_ready (card_ready)
  );

  // Count cmd_valid pulses and remember the index presented with each one
  always @(negedge clk_ref) begin
    if (cmd_valid) begin
      vcount   <= vcount + 1;
      last_idx <= cmd_index;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    sd_mosi = b;
    #80;
    r = sd_miso;
    sd_clk = 1'b1;
    #80;
    sd_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic rb;
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], rb);
      rx = {rx[6:0], rb};
    end
  endtask

  task automatic run_cmd(input logic [47:0] cmd, input int nresp,
                         output logic [7:0] ncr, output logic [63:0] resp);
    logic [7:0] d;
    sd_cs = 1'b0;
    #40;
    for (int i = 5; i >= 0; i--) spi_byte(cmd[i*8 +: 8], d);
    spi_byte(8'hFF, ncr);
    resp = 64'h0;
    for (int i = 0; i < nresp; i++) begin
      spi_byte(8'hFF, d);
      resp = {resp[55:0], d};
    end
    sd_mosi = 1'b1;
    #40;
    sd_cs = 1'b1;
    #200;
  endtask

  initial begin
    logic [7:0]  ncr;
    logic [63:0] resp;
    logic [47:0] partial;
    logic        rb;
    int          v0;

    #52;
    chk("rst_miso", {63'h0, sd_miso}, 64'h1);
    chk("rst_valid", {63'h0, cmd_valid}, 64'h0);
    chk("rst_index", {58'h0, cmd_index}, 64'h0);
    chk("rst_ready", {63'h0, card_ready}, 64'h0);
    rst = 1'b1;
    #100;

    // CMD8 before any CMD0: 64 sd_clk cycles of ones, no cmd_valid
    run_cmd(C_CMD8, 7, ncr, resp);
    chk("pre_cmd0_cmd8_miso", {ncr, resp[55:0]}, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pre_cmd0_cmd8_valid", 64'(vcount), 64'd0);

    // CMD0 aborted after 20 bits
    partial = C_CMD0;
    sd_cs = 1'b0;
    #40;
    for (int i = 47; i >= 28; i--) spi_bit(partial[i], rb);
    sd_mosi = 1'b1;
    #40;
    sd_cs = 1'b1;
    #100;
    chk("abort_miso", {63'h0, sd_miso}, 64'h1);
    chk("abort_valid", 64'(vcount), 64'd0);
    #200;

    // Full CMD0
    run_cmd(C_CMD0, 1, ncr, resp);
    chk("cmd0_ncr", {56'h0, ncr}, 64'hFF);
    chk("cmd0_r1", resp, 64'h01);
    chk("cmd0_valid", 64'(vcount), 64'd1);
    chk("cmd0_index", {58'h0, last_idx}, 64'd0);

    // CMD8 with the accepted check pattern
    run_cmd(C_CMD8, 5, ncr, resp);
    chk("cmd8_ncr", {56'h0, ncr}, 64'hFF);
    chk("cmd8_r7", resp, 64'h01_00_00_01_AA);
    chk("cmd8_index", {58'h0, last_idx}, 64'd8);
    chk("cmd8_valid", 64'(vcount), 64'd2);
    v0 = 2;

`ifndef SDR_CRC_CHECK_EN
    // Unsupported voltage code echoes as 0
    run_cmd(C_CMD8_V0, 5, ncr, resp);
    chk("cmd8_v0_r7", resp, 64'h01_00_00_00_AA);
    v0 = 3;
`endif

    // CMD0 with a corrupted CRC byte
    run_cmd(C_CMD0_BAD, 1, ncr, resp);
`ifdef SDR_CRC_CHECK_EN
    chk("cmd0_badcrc_r1", resp, 64'h09);
`else
    chk("cmd0_badcrc_r1", resp, 64'h01);
`endif

    // Illegal index and ACMD41 index without a preceding CMD55
    run_cmd(C_CMD17, 1, ncr, resp);
    chk("cmd17_illegal", resp, 64'h05);
    run_cmd(C_ACMD41, 1, ncr, resp);
    chk("cmd41_noapp_illegal", resp, 64'h05);

    // Badly framed frames are dropped without cmd_valid
    run_cmd(C_BAD_TX, 1, ncr, resp);
    chk("bad_txbit_resp", {48'h0, ncr, resp[7:0]}, 64'hFFFF);
    run_cmd(C_BAD_END, 1, ncr, resp);
    chk("bad_endbit_resp", {48'h0, ncr, resp[7:0]}, 64'hFFFF);
    chk("bad_frame_valid", 64'(vcount), 64'(v0 + 3));

    // Three CMD55 + ACMD41 rounds: busy, busy, ready
    run_cmd(C_CMD55, 1, ncr, resp);
    chk("cmd55_a", resp, 64'h01);
    run_cmd(C_ACMD41, 1, ncr, resp);
    chk("acmd41_1", resp, 64'h01);
    run_cmd(C_CMD55, 1, ncr, resp);
    chk("cmd55_b", resp, 64'h01);
    run_cmd(C_ACMD41, 1, ncr, resp);
    chk("acmd41_2", resp, 64'h01);
    chk("ready_before", {63'h0, card_ready}, 64'h0);
    run_cmd(C_CMD55, 1, ncr, resp);
    chk("cmd55_c", resp, 64'h01);
    run_cmd(C_ACMD41, 1, ncr, resp);
    chk("acmd41_3", resp, 64'h00);
    chk("acmd41_index", {58'h0, last_idx}, 64'd41);
    chk("ready_after", {63'h0, card_ready}, 64'h1);
    run_cmd(C_CMD55, 1, ncr, resp);
    chk("cmd55_final", resp, 64'h00);

    // After leaving idle: illegal reports 0x04, CMD8 still answers
    run_cmd(C_CMD17, 1, ncr, resp);
    chk("cmd17_ready_illegal", resp, 64'h04);
    run_cmd(C_CMD8, 5, ncr, resp);
    chk("cmd8_ready_r7", resp, 64'h01_00_00_01_AA);

    // CMD0 returns the card to idle
    run_cmd(C_CMD0, 1, ncr, resp);
    chk("cmd0_again_r1", resp, 64'h01);
    chk("cmd0_again_ready", {63'h0, card_ready}, 64'h0);
    chk("cs_high_miso", {63'h0, sd_miso}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
